reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 1024, meaning consecutive synchronized-lock cycles required before bus reset release.
REQ-002 SHALL have parameter STAGE_CYCLES, default 16, meaning cycles between bus reset release and CPU reset release.
REQ-003 SHALL have parameter SWRST_CYCLES, default 64, meaning cycles both resets are held low after a software reset request.
REQ-004 SHALL have port i_clk  input  1  system clock, the 75 MHz PLL output.
REQ-005 SHALL have port i_nrst  input  1  asynchronous active-low reset; the top level delivers its deassertion synchronous to i_clk.
REQ-006 SHALL have port i_pll_locked  input  1  PLL locked flag, asynchronous to i_clk.
REQ-007 SHALL have port i_swrst  input  1  synchronous software reset request, level-sensitive.
REQ-008 SHALL have port o_bus_nrst  output  1  active-low reset for interconnect and peripherals.
REQ-009 SHALL have port o_cpu_nrst  output  1  active-low reset for the CPU core.
REQ-010 SHALL have port o_ready  output  1  high only in state RUN.
REQ-011 SHALL have port o_state  output  3  current state encoding for debug.

Function
REQ-012 SHALL pass i_pll_locked through a two-flop synchronizer; its output is lock_s.
REQ-013 SHALL implement states RESET=0, WAIT_LOCK=1, STABLE=2, REL_BUS=3, RUN=4, SWRST=5; o_state SHALL equal the state register.
REQ-014 SHALL use one 16-bit cycle counter; parameters SHALL each be in range 1..65535.
REQ-015 RESET: next edge -> WAIT_LOCK, counter 0.
REQ-016 WAIT_LOCK: lock_s=1 -> STABLE, counter 0; else stay.
REQ-017 STABLE: counter increments each cycle; lock_s=0 -> WAIT_LOCK; counter = LOCK_CYCLES-1 with lock_s=1 -> REL_BUS, counter 0.
REQ-018 REL_BUS: counter increments; counter = STAGE_CYCLES-1 -> RUN, counter 0.
REQ-019 RUN: i_swrst=1 -> SWRST, counter 0; else stay.
REQ-020 SWRST: counter increments; counter = SWRST_CYCLES-1 -> REL_BUS, counter 0; i_swrst is ignored in this state.
REQ-021 lock_s=0 in REL_BUS, RUN or SWRST SHALL force WAIT_LOCK on the next edge, with priority over i_swrst and counter terminal conditions.
REQ-022 Outputs SHALL be registered and consistent with the state register in the same cycle: o_bus_nrst=1 only in REL_BUS and RUN; o_cpu_nrst=1 and o_ready=1 only in RUN.
REQ-023 Latency: with i_pll_locked first sampled high at edge k and held, state SHALL be STABLE after edge k+2.
REQ-024 With the same condition, o_bus_nrst SHALL rise after edge k+2+LOCK_CYCLES.
REQ-025 With the same condition, o_cpu_nrst SHALL rise after edge k+2+LOCK_CYCLES+STAGE_CYCLES.
REQ-026 o_cpu_nrst SHALL never be 1 while o_bus_nrst is 0.
REQ-027 Every transition into WAIT_LOCK, including mid-count, SHALL clear the counter and drop both resets on the same edge.

Reset
REQ-028 i_nrst=0 SHALL asynchronously force state RESET, counter 0, synchronizer flops 0, o_bus_nrst=0, o_cpu_nrst=0, o_ready=0, o_state=0.
REQ-029 i_nrst assertion mid-sequence, in any state, SHALL restart the full sequence from RESET after deassertion.

Verification
REQ-030 With LOCK_CYCLES=8 and STAGE_CYCLES=4: locked high from edge 0 -> o_bus_nrst rises after edge 10, o_cpu_nrst and o_ready rise after edge 14, o_state=4.
REQ-031 Locked glitch low for 1 cycle during STABLE at count 5 -> return to WAIT_LOCK, counter restarts, bus release delayed by the full LOCK_CYCLES.
REQ-032 In RUN, i_swrst pulse for 1 cycle with SWRST_CYCLES=6 -> both resets low for 6 cycles, then o_bus_nrst high, o_cpu_nrst high 4 cycles later.
REQ-033 In SWRST, locked drops -> WAIT_LOCK next edge, resets stay low until the full lock sequence repeats.
REQ-034 i_nrst pulsed low in REL_BUS -> all outputs 0 immediately, without waiting for a clock edge; o_state=0; after release, o_bus_nrst rises again after 2+LOCK_CYCLES cycles of held lock.
REQ-035 Throughout all scenarios, an assertion SHALL check that o_cpu_nrst=1 implies o_bus_nrst=1 and that o_ready equals o_cpu_nrst.

Source files
------------

// File: rtl/reset_sequencer.sv
// Power-on / software reset sequencer: waits for a stable PLL lock,
// then releases the bus reset and, after a stage delay, the CPU reset.
module reset_sequencer #(
  parameter int LOCK_CYCLES  = 1024,
  parameter int STAGE_CYCLES = 16,
  parameter int SWRST_CYCLES = 64
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_pll_locked,
  input  logic       i_swrst,
  output logic       o_bus_nrst,
  output logic       o_cpu_nrst,
  output logic       o_ready,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_REL_BUS   = 3'd3,
    ST_RUN       = 3'd4,
    ST_SWRST     = 3'd5
  } state_e;

  localparam logic [15:0] LOCK_LAST  = 16'(LOCK_CYCLES - 1);
  localparam logic [15:0] STAGE_LAST = 16'(STAGE_CYCLES - 1);
  localparam logic [15:0] SWRST_LAST = 16'(SWRST_CYCLES - 1);

  logic [1:0]  sync_q;
  logic        lock_s;
  state_e      state_q;
  state_e      state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        bus_q;
  logic        cpu_q;
  logic        bus_d;
  logic        cpu_d;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], i_pll_locked};
    end
  end

  assign lock_s = sync_q[1];

  // Lock loss wins over every counter terminal and over i_swrst.
  always_comb begin
    state_d = state_q;
    cnt_d   = 16'd0;
    unique case (state_q)
      ST_RESET: begin
        state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_REL_BUS;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_REL_BUS: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STAGE_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (i_swrst) begin
          state_d = ST_SWRST;
        end
      end
      ST_SWRST: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == SWRST_LAST) begin
          state_d = ST_REL_BUS;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // Outputs are decoded from the next state so they flip on the
  // same edge as the state register.
  always_comb begin
    bus_d = 1'b0;
    cpu_d = 1'b0;
    if (state_d == ST_REL_BUS || state_d == ST_RUN) begin
      bus_d = 1'b1;
    end
    if (state_d == ST_RUN) begin
      cpu_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ST_RESET;
      cnt_q   <= 16'd0;
      bus_q   <= 1'b0;
      cpu_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bus_q   <= bus_d;
      cpu_q   <= cpu_d;
    end
  end

  assign o_bus_nrst = bus_q;
  assign o_cpu_nrst = cpu_q;
  assign o_ready    = cpu_q;
  assign o_state    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timeline model plus directed scenarios
// covering lock, glitch, software reset, lock loss and async reset.
module tb_reset_sequencer;

  localparam int LOCK  = 8;
  localparam int STAGE = 4;
  localparam int SW    = 6;

  logic       i_clk = 1'b0;
  logic       i_nrst = 1'b0;
  logic       i_pll_locked = 1'b1;
  logic       i_swrst = 1'b0;
  logic       o_bus_nrst;
  logic       o_cpu_nrst;
  logic       o_ready;
  logic [2:0] o_state;

  int errors = 0;
  int checks = 0;

  reset_sequencer #(
    .LOCK_CYCLES (LOCK),
    .STAGE_CYCLES(STAGE),
    .SWRST_CYCLES(SW)
  ) dut (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_pll_locked(i_pll_locked),
    .i_swrst     (i_swrst),
    .o_bus_nrst  (o_bus_nrst),
    .o_cpu_nrst  (o_cpu_nrst),
    .o_ready     (o_ready),
    .o_state     (o_state)
  );

  always #5 i_clk = ~i_clk;

  // Model: phases are expressed as a timeline anchored at the edge
  // where the lock or software-reset sequence started.
  // kind: 0 in reset, 1 waiting for lock, 2 lock timeline, 3 swrst timeline
  int cyc = 0;
  int m_kind = 0;
  int m_start = 0;
  bit s1 = 1'b0;
  bit s2 = 1'b0;

  function automatic int exp_state();
    int t;
    t = cyc - m_start;
    if (m_kind == 0) return 0;
    if (m_kind == 1) return 1;
    if (m_kind == 2) begin
      if (t < LOCK) return 2;
      if (t < LOCK + STAGE) return 3;
      return 4;
    end
    if (t < SW) return 5;
    if (t < SW + STAGE) return 3;
    return 4;
  endfunction

  task automatic model_step();
    int cur;
    bit ls;
    if (!i_nrst) begin
      m_kind = 0;
      s1 = 1'b0;
      s2 = 1'b0;
      return;
    end
    ls  = s2;
    cur = exp_state();
    cyc++;
    if (cur == 0) begin
      m_kind = 1;
    end else if (cur == 1) begin
      if (ls) begin
        m_kind  = 2;
        m_start = cyc;
      end
    end else if (!ls) begin
      m_kind = 1;
    end else if (cur == 4 && i_swrst) begin
      m_kind  = 3;
      m_start = cyc;
    end
    s2 = s1;
    s1 = i_pll_locked;
  endtask

  initial begin
    int es;
    logic eb;
    logic ec;
    forever begin
      @(posedge i_clk);
      model_step();
      #1;
      es = exp_state();
      eb = (es == 3 || es == 4);
      ec = (es == 4);
      checks++;
      if (o_state !== 3'(es)) begin
        errors++;
        $display("FAIL model_state t=%0t: got %0d want %0d", $time, o_state, es);
      end
      checks++;
      if (o_bus_nrst !== eb) begin
        errors++;
        $display("FAIL model_bus t=%0t: got %0b want %0b", $time, o_bus_nrst, eb);
      end
      checks++;
      if (o_cpu_nrst !== ec || o_ready !== ec) begin
        errors++;
        $display("FAIL model_cpu t=%0t: cpu=%0b ready=%0b want %0b",
                 $time, o_cpu_nrst, o_ready, ec);
      end
      checks++;
      assert ((o_bus_nrst || !o_cpu_nrst) && o_ready === o_cpu_nrst)
      else begin
        errors++;
        $display("FAIL invariant t=%0t: bus=%0b cpu=%0b ready=%0b",
                 $time, o_bus_nrst, o_cpu_nrst, o_ready);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [2:0] es,
                     input logic eb, input logic ec);
    checks++;
    if (o_state !== es || o_bus_nrst !== eb ||
        o_cpu_nrst !== ec || o_ready !== ec) begin
      errors++;
      $display("FAIL %s: state=%0d bus=%0b cpu=%0b rdy=%0b, want state=%0d bus=%0b cpu=%0b",
               name, o_state, o_bus_nrst, o_cpu_nrst, o_ready, es, eb, ec);
    end
  endtask

  task automatic power_up(input string tag);
    for (int e = 0; e <= 14; e++) begin
      tick();
      case (e)
        1:  chk({tag, "_wait"}, 3'd1, 1'b0, 1'b0);
        2:  chk({tag, "_stable"}, 3'd2, 1'b0, 1'b0);
        9:  chk({tag, "_bus_hold"}, 3'd2, 1'b0, 1'b0);
        10: chk({tag, "_bus_rel"}, 3'd3, 1'b1, 1'b0);
        13: chk({tag, "_cpu_hold"}, 3'd3, 1'b1, 1'b0);
        14: chk({tag, "_run"}, 3'd4, 1'b1, 1'b1);
        default: ;
      endcase
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("reset", 3'd0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_nrst = 1'b1;
    power_up("boot");

    // Software reset pulse from RUN
    tick();
    @(negedge i_clk);
    i_swrst = 1'b1;
    tick();
    chk("sw_enter", 3'd5, 1'b0, 1'b0);
    @(negedge i_clk);
    i_swrst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      case (e)
        5:  chk("sw_last", 3'd5, 1'b0, 1'b0);
        6:  chk("sw_bus_rel", 3'd3, 1'b1, 1'b0);
        9:  chk("sw_cpu_hold", 3'd3, 1'b1, 1'b0);
        10: chk("sw_run", 3'd4, 1'b1, 1'b1);
        default: ;
      endcase
    end

    // Lose lock, relock, then one-cycle glitch at STABLE count 5
    @(negedge i_clk);
    i_pll_locked = 1'b0;
    repeat (4) tick();
    chk("lock_lost", 3'd1, 1'b0, 1'b0);
    @(negedge i_clk);
    i_pll_locked = 1'b1;
    for (int e = 0; e <= 17; e++) begin
      tick();
      case (e)
        5: begin
          @(negedge i_clk);
          i_pll_locked = 1'b0;
        end
        6: begin
          @(negedge i_clk);
          i_pll_locked = 1'b1;
        end
        7:  chk("glitch_cnt5", 3'd2, 1'b0, 1'b0);
        8:  chk("glitch_wait", 3'd1, 1'b0, 1'b0);
        9:  chk("glitch_restable", 3'd2, 1'b0, 1'b0);
        16: chk("glitch_bus_hold", 3'd2, 1'b0, 1'b0);
        17: chk("glitch_bus_rel", 3'd3, 1'b1, 1'b0);
        default: ;
      endcase
    end
    repeat (4) tick();
    chk("glitch_run", 3'd4, 1'b1, 1'b1);

    // Lock drops while in SWRST
    @(negedge i_clk);
    i_swrst = 1'b1;
    tick();
    chk("sw2_enter", 3'd5, 1'b0, 1'b0);
    @(negedge i_clk);
    i_swrst = 1'b0;
    i_pll_locked = 1'b0;
    tick();
    tick();
    chk("sw2_hold", 3'd5, 1'b0, 1'b0);
    tick();
    chk("sw2_lost", 3'd1, 1'b0, 1'b0);
    repeat (3) tick();
    chk("sw2_wait", 3'd1, 1'b0, 1'b0);
    @(negedge i_clk);
    i_pll_locked = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      tick();
      case (e)
        9:  chk("sw2_bus_hold", 3'd2, 1'b0, 1'b0);
        10: chk("sw2_bus_rel", 3'd3, 1'b1, 1'b0);
        default: ;
      endcase
    end

    // Asynchronous reset pulse in REL_BUS
    #1;
    i_nrst = 1'b0;
    #1;
    chk("async_rst", 3'd0, 1'b0, 1'b0);
    tick();
    chk("async_hold", 3'd0, 1'b0, 1'b0);
    @(negedge i_clk);
    i_nrst = 1'b1;
    power_up("reboot");
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
